mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle controller that implements RV32M unsigned multiply/divide (MUL, MULHU, DIVU, REMU) by driving the shared n-bit ALU once per cycle.
- Uses shift-add for multiply and restoring division for divide/remainder.
- Sits beside the execute stage and borrows the ALU's A/B/control inputs while busy; the pipeline stalls on busy and captures result on done.

Parameters:
- n, 32, datapath width; must match the ALU width (n ≥ 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00=MUL, 01=MULHU, 10=DIVU, 11=REMU.
- rs1  in  n  multiplicand / dividend.
- rs2  in  n  multiplier / divisor.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result valid from this cycle.
- result  out  n  registered result; held until the next operation completes.
- alu_a  out  n  ALU operand A.
- alu_b  out  n  ALU operand B.
- alu_ctrl  out  4  ALU control code: ALU_ADD or ALU_SUB.
- alu_sum  in  n  ALU ALUout (sum or difference).
- alu_c  in  1  ALU carry out; for SUB, 1 means no borrow (A ≥ B).

Behaviour:
- Reset (async, rst=0): state=IDLE, counter=0, all internal registers 0, busy=0, done=0, result=0. Reset asserted mid-operation aborts it; no done is produced.
- FSM states IDLE → RUN → DONE → IDLE.
  - IDLE, start=1: latch op, latch D=rs1 (MUL/MULHU) or D=rs2 (DIV), hi=0, lo=rs2 (MUL/MULHU) or rs1 (DIV), counter=0; go to RUN.
  - RUN: exactly n cycles; counter increments 0..n-1; leaves to DONE after count n-1.
  - DONE: done=1, result loaded; next state IDLE.
- Timing and handshake:
  - start in cycle 0 → done high in cycle n+1.
  - start is ignored while busy, including in the DONE cycle.
  - Back-to-back operations: the earliest next start is in the cycle after DONE.
- ALU drive:
  - RUN, MUL/MULHU: alu_a=hi, alu_b=D, alu_ctrl=ALU_ADD.
  - RUN, DIVU/REMU: alu_a=trial, alu_b=D, alu_ctrl=ALU_SUB.
  - IDLE/DONE: alu_a=0, alu_b=0, alu_ctrl=ALU_ADD.
  - The ALU is combinational; its outputs are consumed in the same cycle.
- Multiply step:
  - If lo[0]=1: {c,s}={alu_c,alu_sum}; else {c,s}={0,hi}.
  - Then {hi,lo} = {c,s,lo[n-1:1]}.
  - After n steps lo = low product, hi = high product.
- Divide step:
  - t=hi[n-1]; trial={hi[n-2:0],lo[n-1]}.
  - If t|alu_c: hi=alu_sum, qbit=1; else hi=trial, qbit=0.
  - lo={lo[n-2:0],qbit}. Final lo=quotient, hi=remainder.
- Result select at DONE: MUL=lo, MULHU=hi, DIVU=lo, REMU=hi.
- Divide by zero needs no special case (no trap); the algorithm itself yields DIVU=all ones and REMU=dividend, per the ISA.
- Overflow: none for unsigned ops; all arithmetic is modulo 2^n except the 2n-bit product.
- Counter width is $clog2(n); no wrap past n-1.

Decomposition:
- Add to the shared defines include:
  - MDU_MUL, MDU_MULHU, MDU_DIVU, MDU_REMU op codes.
  - MDU_IDLE, MDU_RUN, MDU_DONE state encodings.
- Reuse the existing ALU_ADD/ALU_SUB codes; ALU_SUB's control bit 0 is the carry-in the ALU relies on.
- No sub-module: datapath registers and FSM stay in one module, and the ALU instance lives outside it.
- The bench instantiates the project ALU and wires it to the alu_* ports.

Test Plan:
- MUL rs1=7, rs2=6, start at cycle 0 → busy cycles 0..n+1 wait: busy from the cycle after start through DONE; done at cycle 33 (n=32), result=42.
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → result=0xFFFFFFFE; repeat with MUL → 0x00000001.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 0x80000000/1 → 0x80000000 (exercises the t=1 path).
- Divide by zero: DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234; done still at cycle 33.
- Re-assert start with different operands during RUN and during DONE → ignored; result and done timing unchanged.
- Assert rst=0 at cycle 10 of a DIVU → busy=0, done=0, result=0 immediately; a new MUL 3*5 after release → 15 with full latency.

Source files
------------

// File: rtl/mdu_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer and the execute-stage ALU.
// Operation codes, FSM states and the two ALU control codes the sequencer uses.
package mdu_sequencer_pkg;

  typedef enum logic [1:0] {
    MDU_MUL   = 2'b00,
    MDU_MULHU = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_REMU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_e;

  // Bit 0 of the control code is the ALU carry-in, so SUB computes A + ~B + 1.
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIVU) || (op == MDU_REMU);
  endfunction

  function automatic logic op_takes_hi(input mdu_op_e op);
    return (op == MDU_MULHU) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/alu.sv
// Project n-bit adder/subtractor ALU shared by execute and the MDU sequencer.
// Purely combinational; carry out means "no borrow" when subtracting.
module alu
  import mdu_sequencer_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [n-1:0] sum,
  output logic         c
);

  logic [n-1:0] b_eff_s;
  logic [n:0]   total_s;

  // Operand B conditioning and the single adder.
  always_comb begin
    b_eff_s = b;
    case (ctrl)
      ALU_ADD: b_eff_s = b;
      ALU_SUB: b_eff_s = ~b;
      default: b_eff_s = b;
    endcase
    total_s = {1'b0, a} + {1'b0, b_eff_s} + {{n{1'b0}}, ctrl[0]};
  end

  assign sum = total_s[n-1:0];
  assign c   = total_s[n];

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M unsigned MUL/MULHU/DIVU/REMU sequencer: shift-add multiply and restoring
// divide, one step per cycle through the shared external ALU.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] rs1,
  input  logic [n-1:0] rs2,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [n-1:0] alu_sum,
  input  logic         alu_c
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

  mdu_state_e    state_r;
  mdu_op_e       op_r;
  logic [n-1:0]  d_r;
  logic [n-1:0]  hi_r;
  logic [n-1:0]  lo_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic          done_r;
  logic [n-1:0]  result_r;
  logic [n-1:0]  alu_a_r;
  logic [n-1:0]  alu_b_r;
  logic [3:0]    alu_ctrl_r;

  logic [n-1:0]  hi_nx_s;
  logic [n-1:0]  lo_nx_s;
  logic [n-1:0]  sum_s;
  logic          carry_s;
  logic [n-1:0]  trial_s;
  logic          qbit_s;
  logic          start_div_s;

  assign start_div_s = op_is_div(mdu_op_e'(op));

  // One iteration of multiply or divide, using this cycle's ALU result.
  always_comb begin
    hi_nx_s = hi_r;
    lo_nx_s = lo_r;
    sum_s   = hi_r;
    carry_s = 1'b0;
    qbit_s  = 1'b0;
    trial_s = {hi_r[n-2:0], lo_r[n-1]};
    if (op_is_div(op_r)) begin
      // The bit shifted out of hi makes the trial value exceed any divisor.
      if (hi_r[n-1] | alu_c) begin
        hi_nx_s = alu_sum;
        qbit_s  = 1'b1;
      end else begin
        hi_nx_s = trial_s;
        qbit_s  = 1'b0;
      end
      lo_nx_s = {lo_r[n-2:0], qbit_s};
    end else begin
      if (lo_r[0]) begin
        carry_s = alu_c;
        sum_s   = alu_sum;
      end else begin
        carry_s = 1'b0;
        sum_s   = hi_r;
      end
      hi_nx_s = {carry_s, sum_s[n-1:1]};
      lo_nx_s = {sum_s[0], lo_r[n-1:1]};
    end
  end

  // Sequencer FSM, datapath registers and registered ALU drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= MDU_IDLE;
      op_r       <= MDU_MUL;
      d_r        <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      cnt_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= '0;
      alu_a_r    <= '0;
      alu_b_r    <= '0;
      alu_ctrl_r <= ALU_ADD;
    end else begin
      case (state_r)
        MDU_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            op_r       <= mdu_op_e'(op);
            d_r        <= start_div_s ? rs2 : rs1;
            hi_r       <= '0;
            lo_r       <= start_div_s ? rs1 : rs2;
            cnt_r      <= '0;
            state_r    <= MDU_RUN;
            busy_r     <= 1'b1;
            // First operand A is the step-0 view of hi=0 and lo.
            alu_a_r    <= start_div_s ? {{(n-1){1'b0}}, rs1[n-1]} : {n{1'b0}};
            alu_b_r    <= start_div_s ? rs2 : rs1;
            alu_ctrl_r <= start_div_s ? ALU_SUB : ALU_ADD;
          end else begin
            busy_r     <= 1'b0;
            alu_a_r    <= '0;
            alu_b_r    <= '0;
            alu_ctrl_r <= ALU_ADD;
          end
        end
        MDU_RUN: begin
          hi_r <= hi_nx_s;
          lo_r <= lo_nx_s;
          if (cnt_r == CNT_LAST) begin
            state_r    <= MDU_DONE;
            done_r     <= 1'b1;
            result_r   <= op_takes_hi(op_r) ? hi_nx_s : lo_nx_s;
            alu_a_r    <= '0;
            alu_b_r    <= '0;
            alu_ctrl_r <= ALU_ADD;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            alu_a_r <= op_is_div(op_r) ? {hi_nx_s[n-2:0], lo_nx_s[n-1]} : hi_nx_s;
          end
        end
        MDU_DONE: begin
          state_r    <= MDU_IDLE;
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          alu_a_r    <= '0;
          alu_b_r    <= '0;
          alu_ctrl_r <= ALU_ADD;
        end
        default: begin
          state_r    <= MDU_IDLE;
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          alu_a_r    <= '0;
          alu_b_r    <= '0;
          alu_ctrl_r <= ALU_ADD;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign alu_a    = alu_a_r;
  assign alu_b    = alu_b_r;
  assign alu_ctrl = alu_ctrl_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer wired to the project ALU: arithmetic reference model,
// per-cycle output comparison, and directed operations with literal results.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] rs1, rs2;
  logic         busy, done, alu_c;
  logic [N-1:0] result, alu_a, alu_b, alu_sum;
  logic [3:0]   alu_ctrl;

  int checks = 0;
  int errors = 0;

  mdu_sequencer #(.n(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_sum(alu_sum), .alu_c(alu_c)
  );

  alu #(.n(N)) u_alu (
    .a(alu_a), .b(alu_b), .ctrl(alu_ctrl), .sum(alu_sum), .c(alu_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_calc(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Timeline model: k=0 idle, k=1..N computing, k=N+1 the done cycle.
  int          m_k = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pending = 32'd0;
  logic [31:0] m_d = 32'd0;
  logic        m_div = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_k <= 0; m_done <= 1'b0; m_result <= 32'd0;
    end else begin
      m_done <= 1'b0;
      if (m_k == 0) begin
        if (start) begin
          m_k       <= 1;
          m_pending <= ref_calc(op, rs1, rs2);
          m_div     <= op[1];
          m_d       <= op[1] ? rs2 : rs1;
        end
      end else if (m_k == N) begin
        m_k <= N + 1; m_done <= 1'b1; m_result <= m_pending;
      end else if (m_k == N + 1) begin
        m_k <= 0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, (m_k != 0)});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("result", result, m_result);
    if (m_k >= 1 && m_k <= N) begin
      check("alu_ctrl_run", {28'd0, alu_ctrl}, {28'd0, (m_div ? ALU_SUB : ALU_ADD)});
      check("alu_b_run", alu_b, m_d);
    end else begin
      check("alu_ctrl_idle", {28'd0, alu_ctrl}, {28'd0, ALU_ADD});
      check("alu_a_idle", alu_a, 32'd0);
      check("alu_b_idle", alu_b, 32'd0);
    end
  end

  // Start one operation in the next idle cycle, optionally re-poking start while busy.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, input string nm, input bit poke);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < N + 8) begin
      if (poke && lat == 5) begin
        start = 1'b1; op = ~o; rs1 = b + 32'd1; rs2 = a + 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, lat, N + 1);
    check({nm, "_value"}, result, lit);
    if (poke) begin
      start = 1'b1; op = ~o; rs1 = 32'd99; rs2 = 32'd98;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b1;

    do_op(2'b00, 32'd7, 32'd6, 32'd42, "mul_7x6", 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max", 1'b0);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_max", 1'b0);
    do_op(2'b10, 32'd100, 32'd7, 32'd14, "divu_100_7", 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 32'd2, "remu_100_7", 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'd1, 32'h8000_0000, "divu_msb", 1'b0);
    do_op(2'b10, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, "divu_by0", 1'b0);
    do_op(2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, "remu_by0", 1'b0);
    do_op(2'b10, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, "divu_big", 1'b0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, "remu_big", 1'b0);
    do_op(2'b00, 32'd12345, 32'd678, 32'd8369910, "mul_poked", 1'b1);

    // Abort a divide part-way through.
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs1 = 32'd1000; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_op(2'b00, 32'd3, 32'd5, 32'd15, "mul_after_abort", 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
